// File: rtl/cfo_pkg.sv
// Shared definitions for the CFO estimation datapath: FSM state encoding,
// the default data width and the saturation limits for that width.
package cfo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DATA_W = 24;

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Saturated value for an overflow in the direction of the given sign bit.
    function automatic logic [DATA_W-1:0] sat_val(input logic sign);
        return sign ? SAT_MIN : SAT_MAX;
    endfunction

endpackage

// File: rtl/mulpow2_sat.sv
// Sequential signed multiply by 2^k, one bit of shift per clock, with
// saturation to the signed min/max and a sticky overflow flag.
module mulpow2_sat
    import cfo_pkg::*;
#(
    parameter int DATA_W  = cfo_pkg::DATA_W,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DATA_W-1:0]  din,
    input  logic [SHIFT_W-1:0] shift,
    output logic [DATA_W-1:0]  dout,
    output logic               busy,
    output logic               finish,
    output logic               ovf
);

    localparam logic [DATA_W-1:0]  LIM_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]  LIM_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [SHIFT_W-1:0] CNT_ONE = SHIFT_W'(1);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  acc_q,   acc_d;
    logic [SHIFT_W-1:0] cnt_q,   cnt_d;
    logic [DATA_W-1:0]  dout_q,  dout_d;
    logic               ovf_q,   ovf_d;

    logic               acc_will_ovf;
    logic [DATA_W-1:0]  acc_shl;
    logic [DATA_W-1:0]  acc_sat;

    // Shifting left once more is safe only while the top two bits agree.
    assign acc_will_ovf = acc_q[DATA_W-1] ^ acc_q[DATA_W-2];
    assign acc_shl      = {acc_q[DATA_W-2:0], 1'b0};
    assign acc_sat      = acc_q[DATA_W-1] ? LIM_MIN : LIM_MAX;

    // dout and ovf are loaded on the transition into DONE so that they are
    // already valid in the same cycle as the finish pulse.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = din;
                    cnt_d = shift;
                    ovf_d = 1'b0;
                    if (shift == '0) begin
                        state_d = DONE;
                        dout_d  = din;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (acc_will_ovf) begin
                    acc_d   = acc_sat;
                    ovf_d   = 1'b1;
                    dout_d  = acc_sat;
                    state_d = DONE;
                end else begin
                    acc_d = acc_shl;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        dout_d  = acc_shl;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dout   = dout_q;
    assign ovf    = ovf_q;
    assign busy   = (state_q == SHIFT) || (state_q == DONE);
    assign finish = (state_q == DONE);

endmodule

// File: tb/tb_mulpow2_sat.sv
// Directed and round-trip bench for mulpow2_sat; cycle numbers count from the
// edge that accepts start (edge 0), so cycle 1 is the period after that edge.
module tb_mulpow2_sat;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] din;
    logic [4:0]  shift;
    logic [23:0] dout;
    logic        busy;
    logic        finish;
    logic        ovf;

    int n_vec = 0;
    int n_err = 0;

    mulpow2_sat #(.DATA_W(24), .SHIFT_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .din    (din),
        .shift  (shift),
        .dout   (dout),
        .busy   (busy),
        .finish (finish),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 one cycle after finish.
    task automatic run_job(input logic [23:0] d, input logic [4:0] k,
                           output int fin, output logic [23:0] q,
                           output logic o, output bit busy_bad);
        fin      = -1;
        q        = '0;
        o        = 1'b0;
        busy_bad = 1'b0;
        start    = 1'b1;
        din      = d;
        shift    = k;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (!busy) busy_bad = 1'b1;
            if (finish) begin
                fin = c;
                q   = dout;
                o   = ovf;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (busy || finish) busy_bad = 1'b1;
        $display("job din=0x%06h k=%0d -> dout=0x%06h ovf=%0b finish_cycle=%0d",
                 d, k, q, o, fin);
    endtask

    task automatic dir_job(input string tag, input logic [23:0] d, input logic [4:0] k,
                           input logic [23:0] exp_q, input logic exp_o, input int exp_fin);
        int          fin;
        logic [23:0] q;
        logic        o;
        bit          bb;
        run_job(d, k, fin, q, o, bb);
        chk({tag, "_dout"}, 32'(q), 32'(exp_q));
        chk({tag, "_ovf"}, 32'(o), 32'(exp_o));
        chk({tag, "_fin"}, 32'(fin), 32'(exp_fin));
        chk({tag, "_busy"}, 32'(bb), 32'd0);
    endtask

    initial begin
        int          fin;
        int          nfin;
        logic [23:0] q;
        logic        o;
        bit          bb;
        logic [23:0] orig;

        rst   = 1'b1;
        start = 1'b0;
        din   = '0;
        shift = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fin", 32'(finish), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        dir_job("basic", 24'h000003, 5'd4, 24'h000030, 1'b0, 5);
        dir_job("posovf", 24'h400000, 5'd1, 24'h7FFFFF, 1'b1, 2);
        dir_job("minexact", 24'hC00000, 5'd1, 24'h800000, 1'b0, 2);
        dir_job("minovf", 24'hC00000, 5'd2, 24'h800000, 1'b1, 3);
        dir_job("k0", 24'hABCDEF, 5'd0, 24'hABCDEF, 1'b0, 1);
        dir_job("neg1k5", 24'hFFFFFF, 5'd5, 24'hFFFFE0, 1'b0, 6);
        dir_job("neg1k23", 24'hFFFFFF, 5'd23, 24'h800000, 1'b0, 24);
        dir_job("neg1k24", 24'hFFFFFF, 5'd24, 24'h800000, 1'b1, 25);

        repeat (3) @(posedge clk);
        #1;
        chk("hold_dout", 32'(dout), 32'h800000);
        chk("hold_ovf", 32'(ovf), 32'd1);

        dir_job("zero31", 24'h000000, 5'd31, 24'h000000, 1'b0, 32);
        dir_job("onek22", 24'h000001, 5'd22, 24'h400000, 1'b0, 23);
        dir_job("onek23", 24'h000001, 5'd23, 24'h7FFFFF, 1'b1, 24);
        dir_job("negfast", 24'hA00000, 5'd3, 24'h800000, 1'b1, 2);

        // start pulses in cycles 1, 2 and the finish cycle 4 must all be ignored
        nfin  = 0;
        fin   = -1;
        start = 1'b1;
        din   = 24'h000005;
        shift = 5'd3;
        @(posedge clk); #1;
        for (int c = 1; c <= 12; c++) begin
            start = (c == 1) || (c == 2) || (c == 4);
            din   = 24'h000007;
            shift = 5'd0;
            if (finish) begin
                nfin++;
                if (fin < 0) begin
                    fin = c;
                    q   = dout;
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        $display("job din=0x000005 k=3 (extra starts) -> dout=0x%06h finishes=%0d finish_cycle=%0d",
                 q, nfin, fin);
        chk("ign_nfin", 32'(nfin), 32'd1);
        chk("ign_fin", 32'(fin), 32'd4);
        chk("ign_dout", 32'(q), 32'h000028);
        chk("ign_ovf", 32'(ovf), 32'd0);

        // reset in cycle 2 of a shift=6 job aborts it
        start = 1'b1;
        din   = 24'h000001;
        shift = 5'd6;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_fin", 32'(finish), 32'd0);
        chk("abort_dout", 32'(dout), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        nfin = 0;
        for (int c = 0; c < 10; c++) begin
            if (finish || busy) nfin++;
            @(posedge clk); #1;
        end
        $display("job din=0x000001 k=6 (reset in cycle 2) -> activity_after_reset=%0d", nfin);
        chk("abort_quiet", 32'(nfin), 32'd0);
        dir_job("after_rst", 24'h000001, 5'd6, 24'h000040, 1'b0, 7);

        // rst and start together: reset wins
        rst   = 1'b1;
        start = 1'b1;
        din   = 24'h000003;
        shift = 5'd2;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        $display("job din=0x000003 k=2 (with rst) -> busy=%0b dout=0x%06h", busy, dout);
        chk("rstprio_busy", 32'(busy), 32'd0);
        chk("rstprio_dout", 32'(dout), 32'd0);
        @(posedge clk); #1;

        // halve an even positive value, then restore it with a single shift
        for (int i = 0; i < 1000; i++) begin
            orig = {1'b0, 22'($urandom_range(0, 32'h3FFFFF)), 1'b0};
            run_job(orig >> 1, 5'd1, fin, q, o, bb);
            chk("rt_dout", 32'(q), 32'(orig));
            chk("rt_ovf", 32'(o), 32'd0);
            chk("rt_fin", 32'(fin), 32'd2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
